imem_loader: RTL and testbench

- Synthesizable program loader and run controller for the MIPS core's byte-addressed instruction memory.
- Accepts a stream of instruction words and serializes each one into byte writes at consecutive addresses, with parametrised word width and byte order.
- Holds the core stalled until the last word is written, then releases it.
- Detects arrival of the core's PC at the last loaded instruction, or a cycle-count timeout, and halts the core.

---
 rtl/imem_loader_pkg.sv | 33 +++
 rtl/imem_loader_word_serializer.sv | 66 ++++++
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader: FSM states,
// error codes and the byte-lane selector used by the serializer.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SER    = 3'd2,
        ST_RUN    = 3'd3,
        ST_DELAY  = 3'd4,
        ST_HALTED = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    // Widest instruction word the lane selector can handle.
    localparam int LANE_MAX_W = 512;

    // Byte idx of an nb-byte word in write order: lane idx in little-endian
    // order, or counted from the most significant byte in big-endian order.
    function automatic logic [7:0] byte_lane(input logic [LANE_MAX_W-1:0] word,
                                             input int nb,
                                             input int idx,
                                             input logic big_endian);
        int sel;
        sel = big_endian ? (nb - 1 - idx) : idx;
        return 8'(word >> (8 * sel));
    endfunction

endpackage

// File: rtl/imem_loader_word_serializer.sv
// Takes one instruction word and emits it as consecutive byte writes,
// one per cycle, with registered write enable, address and data.
module word_serializer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic [ADDR_W-1:0] base,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              done
);
    import imem_loader_pkg::*;

    localparam int NB = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic BE = (BIG_ENDIAN != 0);

    logic [DATA_W-1:0] word_r;
    logic [IDX_W-1:0]  idx_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        data_r;
    logic              last_byte_s;

    assign last_byte_s = (idx_r == LAST_IDX);

    // Latch a word on load, then present one byte lane per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= '0;
            idx_r  <= '0;
            we_r   <= 1'b0;
            addr_r <= '0;
            data_r <= 8'h00;
        end else if (load) begin
            word_r <= word;
            idx_r  <= '0;
            we_r   <= 1'b1;
            addr_r <= base;
            data_r <= byte_lane(LANE_MAX_W'(word), NB, 0, BE);
        end else if (we_r) begin
            if (last_byte_s) begin
                we_r <= 1'b0;
            end else begin
                idx_r  <= idx_r + IDX_W'(1);
                addr_r <= addr_r + ADDR_W'(1);
                data_r <= byte_lane(LANE_MAX_W'(word_r), NB, int'(idx_r) + 1, BE);
            end
        end else begin
            we_r <= 1'b0;
        end
    end

    assign we   = we_r;
    assign addr = addr_r;
    assign data = data_r;
    assign done = we_r & last_byte_s;

endmodule

// File: rtl/imem_loader.sv
// Program loader and run controller: writes a word stream into byte memory,
// then lets the core run until its PC reaches the last loaded word or times out.
module imem_loader #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 0,
    parameter int HALT_DELAY = 1,
    parameter int MAX_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_last,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [7:0]                 mem_wdata,
    input  logic [ADDR_W-1:0]          pc,
    output logic                       cpu_run,
    output logic                       halted,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] word_count
);
    import imem_loader_pkg::*;

    localparam int NB    = DATA_W / 8;
    localparam int WC_W  = $clog2(DEPTH + 1);
    localparam int CNT_W = 32;

    state_e            state_r, state_d;
    logic [ADDR_W-1:0] base_r, base_d;
    logic [ADDR_W-1:0] halt_pc_r, halt_pc_d;
    logic [WC_W-1:0]   wc_r, wc_d;
    logic [CNT_W-1:0]  cnt_r, cnt_d;
    logic              last_r, last_d;
    logic [1:0]        err_code_r, err_code_d;
    logic              error_r, error_d;
    logic              halted_r, halted_d;
    logic              in_ready_r;
    logic              cpu_run_r;
    logic              ser_load_s;
    logic              ser_done_s;

    word_serializer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ser_load_s),
        .word  (in_data),
        .base  (base_r),
        .we    (mem_we),
        .addr  (mem_addr),
        .data  (mem_wdata),
        .done  (ser_done_s)
    );

    // Next-state and bookkeeping for load, run and halt sequencing.
    always_comb begin
        state_d    = state_r;
        base_d     = base_r;
        halt_pc_d  = halt_pc_r;
        wc_d       = wc_r;
        cnt_d      = cnt_r;
        last_d     = last_r;
        err_code_d = err_code_r;
        error_d    = error_r;
        halted_d   = halted_r;
        ser_load_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALTED, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    base_d     = '0;
                    wc_d       = '0;
                    err_code_d = ERR_NONE;
                    error_d    = 1'b0;
                    halted_d   = 1'b0;
                end else begin
                    state_d = state_r;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_r) begin
                    ser_load_s = 1'b1;
                    last_d     = in_last;
                    state_d    = ST_SER;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SER: begin
                if (ser_done_s) begin
                    wc_d   = wc_r + WC_W'(1);
                    base_d = base_r + ADDR_W'(NB);
                    if (last_r) begin
                        halt_pc_d = base_r;
                        cnt_d     = '0;
                        state_d   = ST_RUN;
                    end else if (wc_r + WC_W'(1) == WC_W'(DEPTH)) begin
                        // Stop before a word beyond DEPTH can be accepted.
                        state_d    = ST_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_OVF;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_SER;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_r + CNT_W'(1);
                if (pc == halt_pc_r) begin
                    if (HALT_DELAY == 0) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = CNT_W'(HALT_DELAY);
                    end
                end else if ((MAX_CYCLES != 0) && (cnt_r + CNT_W'(1) == CNT_W'(MAX_CYCLES))) begin
                    state_d    = ST_ERR;
                    error_d    = 1'b1;
                    err_code_d = ERR_TMO;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DELAY: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers; handshake and run flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            base_r     <= '0;
            halt_pc_r  <= '0;
            wc_r       <= '0;
            cnt_r      <= '0;
            last_r     <= 1'b0;
            err_code_r <= ERR_NONE;
            error_r    <= 1'b0;
            halted_r   <= 1'b0;
            in_ready_r <= 1'b0;
            cpu_run_r  <= 1'b0;
        end else begin
            state_r    <= state_d;
            base_r     <= base_d;
            halt_pc_r  <= halt_pc_d;
            wc_r       <= wc_d;
            cnt_r      <= cnt_d;
            last_r     <= last_d;
            err_code_r <= err_code_d;
            error_r    <= error_d;
            halted_r   <= halted_d;
            in_ready_r <= (state_d == ST_LOAD);
            cpu_run_r  <= (state_d == ST_RUN) || (state_d == ST_DELAY);
        end
    end

    assign in_ready   = in_ready_r;
    assign cpu_run    = cpu_run_r;
    assign halted     = halted_r;
    assign error      = error_r;
    assign err_code   = err_code_r;
    assign word_count = wc_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a little-endian instance (DEPTH 16, timeout 20) and a
// big-endian instance (DEPTH 4, no timeout, zero halt delay) share one stimulus.
module tb_imem_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] le;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, in_last;
    logic [31:0] in_data, pc;

    logic        in_ready_a, mem_we_a, cpu_run_a, halted_a, error_a;
    logic [31:0] mem_addr_a;
    logic [7:0]  mem_wdata_a;
    logic [1:0]  err_code_a;
    logic [4:0]  word_count_a;

    logic        in_ready_b, mem_we_b, cpu_run_b, halted_b, error_b;
    logic [31:0] mem_addr_b;
    logic [7:0]  mem_wdata_b;
    logic [1:0]  err_code_b;
    logic [2:0]  word_count_b;

    imem_loader #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .BIG_ENDIAN(0),
                  .HALT_DELAY(1), .MAX_CYCLES(20)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .pc(pc), .cpu_run(cpu_run_a), .halted(halted_a), .error(error_a),
        .err_code(err_code_a), .word_count(word_count_a)
    );

    imem_loader #(.DATA_W(32), .DEPTH(4), .ADDR_W(32), .BIG_ENDIAN(1),
                  .HALT_DELAY(0), .MAX_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .pc(pc), .cpu_run(cpu_run_b), .halted(halted_b), .error(error_b),
        .err_code(err_code_b), .word_count(word_count_b)
    );

    int   checks = 0;
    int   errors = 0;
    int   wr_b   = 0;
    wr_t  q_a[$];
    wr_t  q_b[$];
    logic [31:0] base_a, base_b;
    int   b_cnt;
    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard for instance A byte writes.
    always @(negedge clk) begin
        if (mem_we_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_write: addr %0h data %0h, expected no write", mem_addr_a, mem_wdata_a);
            end else begin
                wr_t w;
                w = q_a.pop_front();
                check("a_write", {mem_addr_a, mem_wdata_a}, {w.addr, w.data});
            end
        end
    end

    // Scoreboard for instance B byte writes.
    always @(negedge clk) begin
        if (mem_we_b === 1'b1) begin
            wr_b++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_write: addr %0h data %0h, expected no write", mem_addr_b, mem_wdata_b);
            end else begin
                wr_t w;
                w = q_b.pop_front();
                check("b_write", {mem_addr_b, mem_wdata_b}, {w.addr, w.data});
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        base_a = 32'h0;
        base_b = 32'h0;
        b_cnt  = 0;
    endtask

    // Offer one word, wait for A to take it, and queue the bytes each instance must write.
    task automatic send_word(input logic [31:0] data, input logic last, input logic [31:0] le);
        bit ok = 1'b0;
        wr_t w;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (in_ready_a) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake: in_ready stayed %0b, expected 1", in_ready_a);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                w.addr = base_a + 32'(k);
                w.data = 8'(le >> (24 - 8 * k));
                q_a.push_back(w);
            end
            base_a = base_a + 32'd4;
            if (b_cnt < 4) begin
                for (int k = 0; k < 4; k++) begin
                    w.addr = base_b + 32'(k);
                    w.data = 8'(data >> (24 - 8 * k));
                    q_b.push_back(w);
                end
                base_b = base_b + 32'd4;
                b_cnt++;
            end
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // data, last, bytes in little-endian write order (big-endian order is the word itself)
        tbl[0]  = '{32'h8C010004, 1'b0, 32'h0400018C};
        tbl[1]  = '{32'h20420001, 1'b0, 32'h01004220};
        tbl[2]  = '{32'h11223344, 1'b0, 32'h44332211};
        tbl[3]  = '{32'hA5A5F00F, 1'b0, 32'h0FF0A5A5};
        tbl[4]  = '{32'h00000000, 1'b0, 32'h00000000};
        tbl[5]  = '{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF};
        tbl[6]  = '{32'h12345678, 1'b0, 32'h78563412};
        tbl[7]  = '{32'hDEADBEEF, 1'b0, 32'hEFBEADDE};
        tbl[8]  = '{32'h0000000C, 1'b0, 32'h0C000000};
        tbl[9]  = '{32'h03E00008, 1'b0, 32'h0800E003};
        tbl[10] = '{32'h1000FFFF, 1'b1, 32'hFFFF0010};

        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0; pc = 32'h0;
        base_a = 32'h0; base_b = 32'h0; b_cnt = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("a_reset", {in_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, cpu_run_a, halted_a, error_a, err_code_a, word_count_a}, 64'h0);
        check("b_reset", {in_ready_b, mem_we_b, mem_addr_b, mem_wdata_b, cpu_run_b, halted_b, error_b, err_code_b, word_count_b}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 11-word program: A loads it all, B overflows after 4 words.
        start_pulse();
        for (int i = 0; i < 11; i++) begin
            send_word(tbl[i].data, tbl[i].last, tbl[i].le);
            if (i == 2) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("a_ser_no_run", {mem_we_a, cpu_run_a}, 2'b10);
        end
        @(negedge clk);
        check("a_run_rise", {mem_we_a, cpu_run_a}, 2'b01);
        check("a_word_count", word_count_a, 5'd11);
        for (int r = 1; r <= 12; r++) begin
            @(posedge clk);
            #1 pc = 32'(4 * r);
            @(negedge clk);
            check("a_run_halt", {cpu_run_a, halted_a}, (r <= 11) ? 2'b10 : 2'b01);
        end
        check("a_no_error", {error_a, err_code_a}, 3'b000);
        check("b_overflow", {in_ready_b, error_b, err_code_b, word_count_b}, 7'b0_1_01_100);
        check("b_write_count", wr_b, 16);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);

        // Two-word program with PC stuck at 0: A times out, B halts once PC reaches 4.
        pc = 32'h0;
        start_pulse();
        check("a_restart", {in_ready_a, error_a, err_code_a, halted_a, word_count_a}, 10'b1_0_00_0_00000);
        check("b_restart", {in_ready_b, error_b, err_code_b, halted_b, word_count_b}, 8'b1_0_00_0_000);
        send_word(tbl[0].data, 1'b0, tbl[0].le);
        send_word(tbl[1].data, 1'b1, tbl[1].le);
        repeat (4) @(negedge clk);
        for (int r = 0; r <= 20; r++) begin
            @(negedge clk);
            check("a_timeout_run", cpu_run_a, (r < 20) ? 1'b1 : 1'b0);
        end
        check("a_timeout_err", {error_a, err_code_a, halted_a}, 4'b1_10_0);
        check("b_still_run", {cpu_run_b, halted_b}, 2'b10);
        @(posedge clk);
        #1 pc = 32'h4;
        @(negedge clk);
        check("b_match_cycle", {cpu_run_b, halted_b}, 2'b10);
        @(negedge clk);
        check("b_halt_nodelay", {cpu_run_b, halted_b, error_b}, 3'b010);

        // Reset in the middle of word 2, then reload a one-word program.
        start_pulse();
        send_word(tbl[0].data, 1'b0, tbl[0].le);
        send_word(tbl[1].data, 1'b0, tbl[1].le);
        send_word(tbl[2].data, 1'b0, tbl[2].le);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("a_mid_reset", {in_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, cpu_run_a, halted_a, error_a, err_code_a, word_count_a}, 64'h0);
        check("b_mid_reset", {in_ready_b, mem_we_b, mem_addr_b, mem_wdata_b, cpu_run_b, halted_b, error_b, err_code_b, word_count_b}, 64'h0);
        q_a.delete();
        q_b.delete();
        pc = 32'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_pulse();
        check("a_reload_count", word_count_a, 5'd0);
        check("b_reload_count", word_count_b, 3'd0);
        send_word(tbl[0].data, 1'b1, tbl[0].le);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("one_word_r0", {cpu_run_a, halted_a, cpu_run_b, halted_b}, 4'b1010);
        @(negedge clk);
        check("one_word_r1", {cpu_run_a, halted_a, cpu_run_b, halted_b}, 4'b1001);
        @(negedge clk);
        check("one_word_r2", {cpu_run_a, halted_a, cpu_run_b, halted_b}, 4'b0101);
        check("one_word_count", {word_count_a, word_count_b}, 8'b00001_001);
        check("one_word_no_err", {error_a, error_b}, 2'b00);
        check("final_queues", q_a.size() + q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
